// File: rtl/bbox_pkg.sv
// Shared types and constants for the bounding-box scan scheduler.
package bbox_pkg;

   localparam int COORD_W = 11;
   localparam int PIX_W   = 16;
   localparam int ADDR_W  = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      SCAN   = 3'd2,
      LATCH  = 3'd3,
      REPORT = 3'd4,
      ABORT  = 3'd5
   } state_t;

   // Scan budget: three passes over the image plus a small margin.
   function automatic int default_timeout(input int width, input int height);
      return width * height * 3 + 16;
   endfunction

endpackage

// File: rtl/bbox_scan_sched_if.sv
// Result handshake between the scheduler (master) and its consumer (slave).
interface bbox_scan_sched_if;
   import bbox_pkg::*;

   logic [COORD_W-1:0] res_xmin;
   logic [COORD_W-1:0] res_xmax;
   logic [COORD_W-1:0] res_ymin;
   logic [COORD_W-1:0] res_ymax;
   logic               res_empty;
   logic               res_valid;
   logic               res_ready;

   modport master (
      output res_xmin, res_xmax, res_ymin, res_ymax, res_empty, res_valid,
      input  res_ready
   );

   modport slave (
      input  res_xmin, res_xmax, res_ymin, res_ymax, res_empty, res_valid,
      output res_ready
   );

endinterface

// File: rtl/bbox_port_mux.sv
// Frame-buffer read-port arbitration between the scanner and the host.
// The scanner owns the port outright while a scan is being started or run;
// the host is granted whenever it asks at any other time.
module bbox_port_mux
   import bbox_pkg::*;
(
   input  logic              scan_owns,
   input  logic [ADDR_W-1:0] bb_addr,
   input  logic              hst_req,
   input  logic [ADDR_W-1:0] hst_addr,
   input  logic [PIX_W-1:0]  mem_rddata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              hst_gnt,
   output logic [PIX_W-1:0]  bb_rddata,
   output logic [PIX_W-1:0]  hst_rddata
);

   // Steer the shared address and the host grant according to port owner
   always_comb begin
      mem_addr = hst_addr;
      hst_gnt  = 1'b0;
      if (scan_owns) begin
         mem_addr = bb_addr;
         hst_gnt  = 1'b0;
      end else begin
         mem_addr = hst_addr;
         hst_gnt  = hst_req;
      end
   end

   // Read data fans out to both clients; each one qualifies its own copy
   assign bb_rddata  = mem_rddata;
   assign hst_rddata = mem_rddata;

endmodule

// File: rtl/bbox_scan_sched.sv
// Scheduler that starts a bounding-box scan for each resident frame, bounds
// the scan time, latches the result and presents it over a valid/ready
// handshake before releasing the frame buffer back to the writer.
module bbox_scan_sched
   import bbox_pkg::*;
#(
   parameter int WIDTH   = 100,
   parameter int HEIGHT  = 100,
   parameter int TIMEOUT = default_timeout(WIDTH, HEIGHT)
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_ready,
   output logic               frame_ack,
   output logic               bb_start,
   input  logic               bb_done,
   input  logic [ADDR_W-1:0]  bb_addr,
   output logic [PIX_W-1:0]   bb_rddata,
   input  logic [COORD_W-1:0] bb_xmin,
   input  logic [COORD_W-1:0] bb_xmax,
   input  logic [COORD_W-1:0] bb_ymin,
   input  logic [COORD_W-1:0] bb_ymax,
   input  logic               hst_req,
   input  logic [ADDR_W-1:0]  hst_addr,
   output logic               hst_gnt,
   output logic [PIX_W-1:0]   hst_rddata,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic [PIX_W-1:0]   mem_rddata,
   bbox_scan_sched_if.master  res,
   output logic               busy,
   output logic [15:0]        frame_cnt,
   output logic               timeout_err
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t             state;
   state_t             next;
   logic [CNT_W-1:0]   counter;
   logic [COORD_W-1:0] lat_xmin;
   logic [COORD_W-1:0] lat_xmax;
   logic [COORD_W-1:0] lat_ymin;
   logic [COORD_W-1:0] lat_ymax;
   logic               lat_empty;
   logic               valid;
   logic               scan_owns;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next;
      end
   end

   // Next-state decision; bb_done only counts once the scan is underway
   always_comb begin
      next = state;
      case (state)
         IDLE: begin
            if (frame_ready) next = START;
            else             next = IDLE;
         end
         START: next = SCAN;
         SCAN: begin
            if (bb_done)                   next = LATCH;
            else if (counter == CNT_LAST)  next = ABORT;
            else                           next = SCAN;
         end
         LATCH: next = REPORT;
         REPORT: begin
            if (res.res_ready) next = IDLE;
            else               next = REPORT;
         end
         ABORT:   next = IDLE;
         default: next = IDLE;
      endcase
   end

   // Scan-time budget counter, cleared as each scan is launched
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         counter <= '0;
      end else if (state == START) begin
         counter <= '0;
      end else if ((state == SCAN) && !bb_done && (counter != CNT_LAST)) begin
         counter <= counter + CNT_W'(1);
      end else begin
         counter <= counter;
      end
   end

   // Registered control outputs, decoded from the state being entered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bb_start  <= 1'b0;
         frame_ack <= 1'b0;
         valid     <= 1'b0;
         busy      <= 1'b0;
      end else begin
         bb_start  <= (next == START);
         frame_ack <= (next == LATCH) || (next == ABORT);
         valid     <= (next == REPORT);
         busy      <= (next != IDLE);
      end
   end

   // Result capture; held untouched through REPORT, ABORT and IDLE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_xmin  <= '0;
         lat_xmax  <= '0;
         lat_ymin  <= '0;
         lat_ymax  <= '0;
         lat_empty <= 1'b1;
      end else if (state == LATCH) begin
         lat_xmin  <= bb_xmin;
         lat_xmax  <= bb_xmax;
         lat_ymin  <= bb_ymin;
         lat_ymax  <= bb_ymax;
         lat_empty <= (bb_xmin > bb_xmax) || (bb_ymin > bb_ymax);
      end else begin
         lat_xmin  <= lat_xmin;
         lat_xmax  <= lat_xmax;
         lat_ymin  <= lat_ymin;
         lat_ymax  <= lat_ymax;
         lat_empty <= lat_empty;
      end
   end

   // Completed-frame counter (wraps naturally) and sticky timeout flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt   <= 16'd0;
         timeout_err <= 1'b0;
      end else begin
         if (state == LATCH) frame_cnt <= frame_cnt + 16'd1;
         else                frame_cnt <= frame_cnt;
         if (next == ABORT)  timeout_err <= 1'b1;
         else                timeout_err <= timeout_err;
      end
   end

   assign res.res_xmin  = lat_xmin;
   assign res.res_xmax  = lat_xmax;
   assign res.res_ymin  = lat_ymin;
   assign res.res_ymax  = lat_ymax;
   assign res.res_empty = lat_empty;
   assign res.res_valid = valid;

   // The scanner holds the frame-buffer port from launch until it finishes
   assign scan_owns = (state == START) || (state == SCAN);

   bbox_port_mux u_port_mux (
      .scan_owns  (scan_owns),
      .bb_addr    (bb_addr),
      .hst_req    (hst_req),
      .hst_addr   (hst_addr),
      .mem_rddata (mem_rddata),
      .mem_addr   (mem_addr),
      .hst_gnt    (hst_gnt),
      .bb_rddata  (bb_rddata),
      .hst_rddata (hst_rddata)
   );

endmodule

// File: tb/tb_bbox_scan_sched.sv
// Self-checking bench for bbox_scan_sched: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// frame-level behavioural model.
`timescale 1ns/1ps
module tb_bbox_scan_sched;
   import bbox_pkg::*;

   localparam int TO = 50;
   localparam int P_IDLE = 0, P_START = 1, P_SCAN = 2, P_LATCH = 3, P_REPORT = 4, P_ABORT = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_ready = 1'b0;
   logic        frame_ack, bb_start, hst_gnt, busy, timeout_err;
   logic        bb_done = 1'b0;
   logic        hst_req = 1'b0;
   logic [31:0] bb_addr = 32'd0, hst_addr = 32'd0, mem_addr;
   logic [15:0] bb_rddata, hst_rddata, mem_rddata, frame_cnt;
   logic [10:0] bb_xmin = 11'd0, bb_xmax = 11'd0, bb_ymin = 11'd0, bb_ymax = 11'd0;

   int n_checks = 0;
   int n_fail   = 0;

   // scanner and stimulus state
   int lat = 12;          // 0 = scanner never finishes
   int sc_cnt = -1;
   bit start_seen = 1'b0;
   bit rnd = 1'b0;

   // behavioural model state
   int          m_ph = P_IDLE;
   int          m_cnt = 0;
   logic [10:0] m_res [4] = '{11'd0, 11'd0, 11'd0, 11'd0};
   logic        m_empty = 1'b1;
   logic [15:0] m_frames = 16'd0;
   logic        m_terr = 1'b0;

   bbox_scan_sched_if rif ();

   bbox_scan_sched #(.TIMEOUT(TO)) dut (
      .clk (clk), .rst (rst),
      .frame_ready (frame_ready), .frame_ack (frame_ack),
      .bb_start (bb_start), .bb_done (bb_done),
      .bb_addr (bb_addr), .bb_rddata (bb_rddata),
      .bb_xmin (bb_xmin), .bb_xmax (bb_xmax), .bb_ymin (bb_ymin), .bb_ymax (bb_ymax),
      .hst_req (hst_req), .hst_addr (hst_addr), .hst_gnt (hst_gnt), .hst_rddata (hst_rddata),
      .mem_addr (mem_addr), .mem_rddata (mem_rddata),
      .res (rif),
      .busy (busy), .frame_cnt (frame_cnt), .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] memf(input logic [31:0] a);
      return a[15:0] ^ {a[7:0], a[31:24]} ^ 16'h5a5a;
   endfunction

   assign mem_rddata = memf(mem_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // one clock: scanner behaviour plus input stimulus, applied just after the edge
   task automatic tick();
      @(posedge clk);
      #1;
      if (start_seen) begin
         if (rnd) begin
            lat = $urandom_range(1, 58);
            bb_xmin = 11'($urandom_range(0, 120));
            bb_xmax = 11'($urandom_range(0, 120));
            bb_ymin = 11'($urandom_range(0, 120));
            bb_ymax = 11'($urandom_range(0, 120));
         end
         bb_done = 1'b0;
         sc_cnt = (lat > 0) ? lat - 1 : -1;
      end else if (sc_cnt > 0) begin
         sc_cnt--;
      end
      if (!start_seen && sc_cnt == 0) begin
         bb_done = 1'b1;
         sc_cnt = -1;
      end
      start_seen = bb_start;
      bb_addr  = $urandom;
      hst_addr = $urandom;
      if (rnd) begin
         hst_req = 1'($urandom_range(0, 1));
         frame_ready = ($urandom_range(0, 3) != 0);
         rif.res_ready = ($urandom_range(0, 2) != 0);
      end else begin
         hst_req = 1'b1;
      end
   endtask

   // run one frame from IDLE until the scheduler is idle again
   task automatic run_frame(input int latency, output int t_start, output int t_done,
                            output int t_valid, output int t_ack, output int acks);
      bit fin;
      t_start = -1; t_done = -1; t_valid = -1; t_ack = -1; acks = 0; fin = 1'b0;
      lat = latency;
      frame_ready = 1'b1;
      for (int t = 1; t <= 300 && !fin; t++) begin
         tick();
         if (bb_start && t_start < 0) begin
            t_start = t;
            frame_ready = 1'b0;
         end
         if (frame_ack) begin
            acks++;
            if (t_ack < 0) t_ack = t;
         end
         if (bb_done && t_done < 0 && t_start >= 0 && t > t_start) t_done = t;
         if (rif.res_valid && t_valid < 0) t_valid = t;
         if (t_start >= 0 && !busy) fin = 1'b1;
      end
      if (!fin) chk("frame_completion_budget", 32'd0, 32'd1);
   endtask

   // frame-level reference model, advanced on every clock edge
   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_ph = P_IDLE; m_cnt = 0; m_res = '{11'd0, 11'd0, 11'd0, 11'd0};
         m_empty = 1'b1; m_frames = 16'd0; m_terr = 1'b0;
      end else begin
         case (m_ph)
            P_IDLE:   if (frame_ready) m_ph = P_START;
            P_START:  begin m_cnt = 0; m_ph = P_SCAN; end
            P_SCAN: begin
               if (bb_done) m_ph = P_LATCH;
               else if (m_cnt == TO - 1) begin m_ph = P_ABORT; m_terr = 1'b1; end
               else m_cnt++;
            end
            P_LATCH: begin
               m_res = '{bb_xmin, bb_xmax, bb_ymin, bb_ymax};
               m_empty = (bb_xmin > bb_xmax) || (bb_ymin > bb_ymax);
               m_frames = m_frames + 16'd1;
               m_ph = P_REPORT;
            end
            P_REPORT: if (rif.res_ready) m_ph = P_IDLE;
            P_ABORT:  m_ph = P_IDLE;
            default:  m_ph = P_IDLE;
         endcase
      end
   end

   // per-cycle comparison of every DUT output against the model
   initial forever begin
      logic        scan;
      logic [31:0] ea;
      @(negedge clk);
      if (!rst) begin
         scan = (m_ph == P_START) || (m_ph == P_SCAN);
         ea   = scan ? bb_addr : hst_addr;
         chk("bb_start",    32'(bb_start),    32'(m_ph == P_START));
         chk("frame_ack",   32'(frame_ack),   32'((m_ph == P_LATCH) || (m_ph == P_ABORT)));
         chk("res_valid",   32'(rif.res_valid), 32'(m_ph == P_REPORT));
         chk("busy",        32'(busy),        32'(m_ph != P_IDLE));
         chk("res_xmin",    32'(rif.res_xmin), 32'(m_res[0]));
         chk("res_xmax",    32'(rif.res_xmax), 32'(m_res[1]));
         chk("res_ymin",    32'(rif.res_ymin), 32'(m_res[2]));
         chk("res_ymax",    32'(rif.res_ymax), 32'(m_res[3]));
         chk("res_empty",   32'(rif.res_empty), 32'(m_empty));
         chk("frame_cnt",   32'(frame_cnt),   32'(m_frames));
         chk("timeout_err", 32'(timeout_err), 32'(m_terr));
         chk("mem_addr",    mem_addr,         ea);
         chk("hst_gnt",     32'(hst_gnt),     32'(scan ? 1'b0 : hst_req));
         chk("bb_rddata",   32'(bb_rddata),   32'(memf(ea)));
         chk("hst_rddata",  32'(hst_rddata),  32'(memf(ea)));
      end
   end

   initial begin
      int ts, td, tv, ta, na, nstart;
      rif.res_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("reset_res_empty", 32'(rif.res_empty), 32'd1);

      // nominal frame with a 12-cycle scanner
      bb_xmin = 11'd10; bb_xmax = 11'd40; bb_ymin = 11'd5; bb_ymax = 11'd60;
      run_frame(12, ts, td, tv, ta, na);
      chk("t1_start_latency", 32'(ts), 32'd1);
      chk("t1_done_to_valid", 32'(tv - td), 32'd2);
      chk("t1_valid_cycle", 32'(tv), 32'd15);
      chk("t1_acks", 32'(na), 32'd1);
      chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
      chk("t1_xmin", 32'(rif.res_xmin), 32'd10);
      chk("t1_xmax", 32'(rif.res_xmax), 32'd40);
      chk("t1_ymin", 32'(rif.res_ymin), 32'd5);
      chk("t1_ymax", 32'(rif.res_ymax), 32'd60);
      chk("t1_empty", 32'(rif.res_empty), 32'd0);

      // empty box; the done level from the previous scan is still high at START
      bb_xmin = 11'd99; bb_xmax = 11'd0; bb_ymin = 11'd99; bb_ymax = 11'd0;
      run_frame(7, ts, td, tv, ta, na);
      chk("t2_empty", 32'(rif.res_empty), 32'd1);
      chk("t2_xmin", 32'(rif.res_xmin), 32'd99);
      chk("t2_frame_cnt", 32'(frame_cnt), 32'd2);

      // scanner never finishes: abort after 50 scan cycles
      run_frame(0, ts, td, tv, ta, na);
      chk("t3_abort_cycle", 32'(ta), 32'd52);
      chk("t3_acks", 32'(na), 32'd1);
      chk("t3_no_valid", 32'(tv), 32'hffffffff);
      chk("t3_timeout_err", 32'(timeout_err), 32'd1);
      chk("t3_frame_cnt", 32'(frame_cnt), 32'd2);
      chk("t3_res_kept", 32'(rif.res_xmin), 32'd99);

      // consumer stalls for 20 cycles while another frame is waiting
      bb_xmin = 11'd3; bb_xmax = 11'd8; bb_ymin = 11'd4; bb_ymax = 11'd9;
      lat = 5; rif.res_ready = 1'b0; frame_ready = 1'b1;
      tv = 0;
      for (int t = 0; t < 100 && !rif.res_valid; t++) begin
         tick();
         if (bb_start) tv++;
      end
      chk("t4_reached_report", 32'(rif.res_valid), 32'd1);
      nstart = 0;
      for (int t = 0; t < 20; t++) begin
         tick();
         if (bb_start) nstart++;
         if (rif.res_xmin != 11'd3 || rif.res_ymax != 11'd9 || !rif.res_valid) nstart += 100;
      end
      chk("t4_stall_stable", 32'(nstart), 32'd0);
      rif.res_ready = 1'b1;
      tick();
      tick();
      chk("t4_restart", 32'(bb_start), 32'd1);
      frame_ready = 1'b0;
      for (int t = 0; t < 100 && busy; t++) tick();
      chk("t4_frame_cnt", 32'(frame_cnt), 32'd4);

      // reset between clock edges in the middle of a scan
      lat = 30; frame_ready = 1'b1;
      for (int t = 0; t < 10 && !bb_start; t++) tick();
      frame_ready = 1'b0;
      repeat (4) tick();
      chk("t5_in_scan", 32'(busy), 32'd1);
      @(posedge clk);
      #2 rst = 1'b1;
      sc_cnt = -1; start_seen = 1'b0; bb_done = 1'b0;
      #1;
      chk("t5_bb_start", 32'(bb_start), 32'd0);
      chk("t5_frame_ack", 32'(frame_ack), 32'd0);
      chk("t5_res_valid", 32'(rif.res_valid), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_res_empty", 32'(rif.res_empty), 32'd1);
      chk("t5_res_xmin", 32'(rif.res_xmin), 32'd0);
      chk("t5_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("t5_timeout_err", 32'(timeout_err), 32'd0);
      chk("t5_hst_gnt", 32'(hst_gnt), 32'd1);
      chk("t5_mem_addr", mem_addr, hst_addr);
      #1 rst = 1'b0;
      na = 0;
      for (int t = 0; t < 6; t++) begin
         tick();
         if (frame_ack) na++;
      end
      chk("t5_no_ack", 32'(na), 32'd0);
      chk("t5_cnt_after", 32'(frame_cnt), 32'd0);

      // randomized traffic, checked by the per-cycle model compare
      rnd = 1'b1;
      repeat (600) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
